// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS bit positions, FSM states.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_RX_FERR   = 4;
  localparam int ST_TX_DROP   = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, combinational head (dout valid while !empty); 1-cycle push-to-pop.
// Push when full is dropped unless a pop in the same cycle frees the slot.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]  count;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/iobus_uart.sv
// IOBUS-mapped 8N1 UART: 8-deep TX FIFO + serializer, 1-byte RX holding register, comb read data.
// TX line falls 2 cycles after an accepted write when idle; writes to a full FIFO are dropped (tx_drop).
module iobus_uart
  import uart_pkg::*;
#(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_AD    = 32'h11100000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_RDATA,
  output logic        IOBUS_SEL,
  input  logic        RX,
  output logic        TX
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  // ---------------- bus decode ----------------
  logic sel_data, sel_stat, wr_data, wr_stat;

  assign sel_data  = (IOBUS_ADDR == BASE_AD + DATA_OFS);
  assign sel_stat  = (IOBUS_ADDR == BASE_AD + STATUS_OFS);
  assign IOBUS_SEL = sel_data || sel_stat;
  assign wr_data   = IOBUS_WR && sel_data;
  assign wr_stat   = IOBUS_WR && sel_stat;

  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT[31:8];

  // ---------------- TX FIFO ----------------
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (IOBUS_OUT[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- TX serializer ----------------
  uart_state_t   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          tx_q;
  logic          tx_cnt_end, tx_empty;

  assign tx_cnt_end = (tx_cnt_q == CNT_LAST);
  // The head is taken either from idle or on the last stop-bit cycle, so frames run back-to-back.
  assign fifo_pop   = !fifo_empty &&
                      ((tx_state_q == IDLE) || ((tx_state_q == STOP) && tx_cnt_end));
  assign tx_empty   = fifo_empty && (tx_state_q == IDLE);
  assign TX         = tx_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            tx_sh_q    <= fifo_dout;
            tx_cnt_q   <= '0;
            tx_state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (tx_cnt_end) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        DATA: begin
          tx_q <= tx_sh_q[0];
          if (tx_cnt_end) begin
            tx_cnt_q <= '0;
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_q <= STOP;
            else                  tx_bit_q   <= tx_bit_q + 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (tx_cnt_end) begin
            tx_cnt_q <= '0;
            if (!fifo_empty) begin
              tx_sh_q    <= fifo_dout;
              tx_state_q <= START;
            end else begin
              tx_state_q <= IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  logic          rx_meta_q, rx_s_q;
  uart_state_t   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_arm_q;
  logic          rx_mid, rx_stop_ok, rx_stop_bad;

  assign rx_mid      = (rx_cnt_q == '0);
  assign rx_stop_ok  = (rx_state_q == STOP) && rx_mid && rx_s_q;
  assign rx_stop_bad = (rx_state_q == STOP) && rx_mid && !rx_s_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // After a framing error the line may sit low; rx_arm_q blocks re-triggering until it returns high.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_arm_q   <= 1'b1;
    end else begin
      case (rx_state_q)
        IDLE: begin
          if (!rx_arm_q) begin
            if (rx_s_q) rx_arm_q <= 1'b1;
          end else if (!rx_s_q) begin
            rx_cnt_q   <= CNT_HALF;
            rx_state_q <= START;
          end
        end
        START: begin
          if (rx_mid) begin
            if (rx_s_q) begin
              rx_state_q <= IDLE;
            end else begin
              rx_cnt_q   <= CNT_LAST;
              rx_bit_q   <= '0;
              rx_state_q <= DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (rx_mid) begin
            rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
            rx_cnt_q <= CNT_LAST;
            if (rx_bit_q == 3'd7) rx_state_q <= STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (rx_mid) begin
            rx_state_q <= IDLE;
            if (!rx_s_q) rx_arm_q <= 1'b0;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- status flags and RX holding register ----------------
  logic       rx_valid_q, rx_ovr_q, rx_ferr_q, tx_drop_q;
  logic       rx_valid_d, rx_ovr_d, rx_ferr_d, tx_drop_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       tx_drop_set;

  assign tx_drop_set = wr_data && fifo_full && !fifo_pop;

  // Clears are applied first so a same-cycle hardware set takes priority.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    tx_drop_d  = tx_drop_q;
    rx_byte_d  = rx_byte_q;
    if (wr_stat) begin
      if (IOBUS_OUT[ST_RX_VALID]) rx_valid_d = 1'b0;
      if (IOBUS_OUT[ST_RX_OVR])   rx_ovr_d   = 1'b0;
      if (IOBUS_OUT[ST_RX_FERR])  rx_ferr_d  = 1'b0;
      if (IOBUS_OUT[ST_TX_DROP])  tx_drop_d  = 1'b0;
    end
    if (rx_stop_ok) begin
      rx_byte_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q) rx_ovr_d = 1'b1;
    end
    if (rx_stop_bad) rx_ferr_d = 1'b1;
    if (tx_drop_set) tx_drop_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_drop_q  <= tx_drop_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] status_w;

  assign status_w = {26'b0, tx_drop_q, rx_ferr_q, rx_ovr_q, rx_valid_q, tx_empty, fifo_full};

  always_comb begin
    IOBUS_RDATA = '0;
    if (sel_data)      IOBUS_RDATA = {24'b0, rx_byte_q};
    else if (sel_stat) IOBUS_RDATA = status_w;
  end

endmodule

// File: tb/tb_iobus_uart.sv
// Directed self-checking bench for iobus_uart at DIV=10 (CLK_HZ=1000, BAUD=100).
module tb_iobus_uart;

  localparam logic [31:0] BASE   = 32'h11100000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iobus_addr = A_STAT;
  logic [31:0] iobus_out = '0;
  logic        iobus_wr = 1'b0;
  logic [31:0] iobus_rdata;
  logic        iobus_sel;
  logic        rx = 1'b1;
  logic        tx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iobus_uart #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (8),
    .BASE_AD    (BASE)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .IOBUS_ADDR  (iobus_addr),
    .IOBUS_OUT   (iobus_out),
    .IOBUS_WR    (iobus_wr),
    .IOBUS_RDATA (iobus_rdata),
    .IOBUS_SEL   (iobus_sel),
    .RX          (rx),
    .TX          (tx)
  );

  typedef struct {
    logic [31:0] addr;
    logic        sel;
    logic [31:0] rdata;
  } rd_vec_t;

  rd_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    step(1);
    iobus_wr   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    iobus_addr = a;
    #1;
    check(name, iobus_rdata, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    step(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(10);
    end
    rx = stop_bit;
    step(10);
    rx = 1'b1;
    step(5);
  endtask

  // Polls for a start bit, then samples each bit at its middle.
  task automatic tx_frame(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int n = 0; n < 300; n++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (ok) begin
      step(5);
      check("frame_start_mid", tx, 0);
      for (int i = 0; i < 8; i++) begin
        step(10);
        b[i] = tx;
      end
      step(10);
      check("frame_stop", tx, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    vecs[0] = '{A_DATA,        1'b1, 32'h0};
    vecs[1] = '{A_STAT,        1'b1, 32'h2};
    vecs[2] = '{32'h11000000,  1'b0, 32'h0};
    vecs[3] = '{BASE + 32'd8,  1'b0, 32'h0};
    vecs[4] = '{BASE + 32'd1,  1'b0, 32'h0};
    a5 = 8'hA5;

    // reset state
    step(3);
    check("rst_tx", tx, 1);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 5; i++) begin
      iobus_addr = vecs[i].addr;
      #1;
      check($sformatf("tbl_sel[%0d]", i), iobus_sel, vecs[i].sel);
      check($sformatf("tbl_rdata[%0d]", i), iobus_rdata, vecs[i].rdata);
    end
    step(1);

    // single byte 0xA5 with exact latency and bit width
    bus_write(A_DATA, 32'h000000A5);
    check("tx_busy_status", iobus_rdata, 0);
    step(1);
    check("tx_lat_k1", tx, 1);
    step(1);
    check("tx_lat_k2", tx, 0);
    step(9);
    check("start_len_t9", tx, 0);
    step(1);
    check("bit0_edge_t10", tx, 1);
    step(5);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_bit%0d", i), tx, a5[i]);
      step(10);
    end
    check("a5_stop", tx, 1);
    step(3);
    read_check("status_in_stop", A_STAT, 32'h0);
    step(1);
    read_check("status_after_stop", A_STAT, 32'h2);
    step(5);

    // async reset mid-frame
    bus_write(A_DATA, 32'h0000005A);
    step(4);
    check("pre_rst_tx", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx, 1);
    step(3);
    rst_n = 1'b1;
    step(2);
    read_check("rst_status", A_STAT, 32'h2);
    step(20);
    check("rst_no_resume", tx, 1);

    // ten back-to-back writes: nine fit, the tenth is dropped
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          iobus_addr = A_DATA;
          iobus_out  = i;
          iobus_wr   = 1'b1;
          step(1);
        end
        iobus_wr = 1'b0;
        read_check("btb_full_drop", A_STAT, 32'h21);
      end
      begin
        logic [7:0] got;
        bit ok;
        for (int j = 1; j <= 9; j++) begin
          tx_frame(got, ok);
          check("btb_frame_found", ok, 1);
          check($sformatf("btb_byte%0d", j), got, j);
        end
      end
    join
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 150; n++) begin
        if (tx === 1'b0) seen = 1'b1;
        step(1);
      end
      check("no_tenth_frame", seen, 0);
    end
    read_check("btb_drop_sticky", A_STAT, 32'h22);
    step(1);
    bus_write(A_STAT, 32'h00000020);
    read_check("drop_w1c", A_STAT, 32'h2);
    step(1);

    // receive path
    send_rx(8'h3C, 1'b1);
    read_check("rx1_status", A_STAT, 32'h6);
    read_check("rx1_data", A_DATA, 32'h3C);
    step(1);
    send_rx(8'h55, 1'b1);
    read_check("rx2_overrun", A_STAT, 32'hE);
    read_check("rx2_data", A_DATA, 32'h55);
    step(1);
    bus_write(A_STAT, 32'h0000000C);
    read_check("rx_w1c", A_STAT, 32'h2);
    step(1);

    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(20);
    read_check("glitch_status", A_STAT, 32'h2);
    read_check("glitch_data", A_DATA, 32'h55);
    step(1);

    send_rx(8'h81, 1'b0);
    read_check("ferr_status", A_STAT, 32'h12);
    read_check("ferr_data", A_DATA, 32'h55);
    step(1);
    send_rx(8'h96, 1'b1);
    read_check("rearm_status", A_STAT, 32'h16);
    read_check("rearm_data", A_DATA, 32'h96);

    iobus_addr = 32'h11000000;
    #1;
    check("unmapped_sel", iobus_sel, 0);
    check("unmapped_rdata", iobus_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iobus_uart.md
Name: iobus_uart

Overview:
- Memory-mapped 8N1 UART peripheral on the OTTER IOBUS; sits directly downstream of the wrapper's IOBUS decode and drives the RX/TX board pins.
- CPU writes bytes into an 8-entry TX FIFO, which the serializer drains.
- Received bytes are held in a one-byte RX holding register with status flags.
- Read data is returned combinationally for the wrapper's IOBUS_in mux.

Parameters:
- CLK_HZ, 50000000, MCU clock frequency (sclk).
- BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit, computed at elaboration; DIV >= 4 required.
- FIFO_DEPTH, 8, TX FIFO entries; power of two.
- BASE_AD, 32'h11100000, base address; DATA = BASE+0, STATUS = BASE+4.

Ports:
- CLK  in  1  MCU clock (sclk domain).
- RESET_N  in  1  asynchronous, active-low reset.
- IOBUS_ADDR  in  32  bus address.
- IOBUS_OUT  in  32  write data from MCU.
- IOBUS_WR  in  1  write strobe, one cycle per store.
- IOBUS_RDATA  out  32  read data; 0 when address not decoded.
- IOBUS_SEL  out  1  high when IOBUS_ADDR equals DATA or STATUS.
- RX  in  1  serial input, asynchronous to CLK.
- TX  out  1  serial output, idle high.

Behaviour:
- Reset (async assert, sync release of internal state):
  - TX=1; FIFO empty; rx_valid=0, rx_overrun=0, rx_frame_err=0, tx_drop=0; both FSMs IDLE; RX synchronizer flops preset to 1.
- Write DATA (IOBUS_WR && addr==DATA):
  - Push IOBUS_OUT[7:0] if FIFO not full.
  - If full, byte discarded and tx_drop set (sticky).
- Write STATUS: write-1-to-clear for bit2 rx_valid, bit3 rx_overrun, bit4 rx_frame_err, bit5 tx_drop; other bits ignored.
- Read DATA: IOBUS_RDATA = {24'b0, rx_byte}. Reads have no side effects; the IOBUS has no read strobe.
- Read STATUS: {26'b0, tx_drop, rx_frame_err, rx_overrun, rx_valid, tx_empty, tx_full}.
  - tx_empty = FIFO empty AND TX FSM IDLE.
- Simultaneous push and pop in the same cycle when full: the pop frees the slot, so the push is accepted.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when FIFO not empty, pop the head the next cycle and enter START.
  - START, DATA, STOP each hold TX for exactly DIV clocks per bit: 0, then d[0]..d[7] LSB first, then 1.
  - Back-to-back bytes: STOP goes directly to START when the FIFO is not empty; no extra idle bit.
  - Latency: TX falls 2 cycles after the accepting write edge when idle.
- RX path:
  - RX passes through a 2-flop synchronizer.
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on a synced falling level (rx_s==0), load the counter with DIV/2 and enter START.
  - START: at mid-bit, if rx_s==1 the edge was a glitch and the FSM returns to IDLE; otherwise enter DATA.
  - DATA: sample every DIV clocks, 8 bits, shift in LSB first.
  - STOP: sample mid-bit.
    - If 1: rx_byte updates; rx_overrun set if rx_valid was already 1; rx_valid set.
    - If 0: rx_frame_err set, rx_byte and rx_valid unchanged; FSM waits in IDLE for rx_s==1 before re-arming.
- Simultaneous rx_valid set and W1C clear in the same cycle: the set wins.
- Counters: bit timer width is $clog2(DIV). FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is natural.

Decomposition:
- Package uart_pkg holds:
  - Register offsets DATA_OFS=0, STATUS_OFS=4.
  - STATUS bit index constants.
  - Enum uart_state_t {IDLE, START, DATA, STOP} shared by both FSMs.
- One sub-module: uart_fifo (synchronous FIFO; ports push, pop, din, dout, full, empty). The serializer and deserializer stay in the top module.

Test Plan (bench uses CLK_HZ=1000, BAUD=100, so DIV=10):
- Reset with RESET_N=0 mid-frame -> TX=1 immediately; STATUS reads 32'h2 after release.
- Write DATA 32'h000000A5 -> TX low for 10 clocks, then bits 1,0,1,0,0,1,0,1 each 10 clocks, then high; STATUS reads 2 after the stop bit.
- Write 9 bytes 0x01..0x09 back-to-back while idle -> 0x01 is popped immediately, so all 9 are accepted with no drop. A 10th byte written in the next cycle is accepted only if the FIFO is not full; with 10 writes in 10 cycles, tx_drop (bit5) is set and byte 0x0A is absent on the line.
- Drive RX frame for 0x3C -> STATUS bit2=1, DATA reads 32'h3C. Send a second byte 0x55 without clearing -> bit3 set, DATA=0x55. Write STATUS 32'h0C -> bits 2 and 3 cleared.
- RX low pulse of 3 clocks -> no byte received, flags unchanged. RX frame with stop bit 0 -> bit4 set, rx_valid unchanged.
- Read an unmapped address 32'h11000000 -> IOBUS_SEL=0, IOBUS_RDATA=0.
